// File: rtl/uart_program_loader.sv
// Boot-time program loader: pops framed bytes from the UART RX FIFO, assembles
// little-endian words and writes them to memory, then flags done or error.
module uart_program_loader #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_fifo_empty,
    output logic        uart_read,
    input  logic [7:0]  uart_read_data,
    output logic        memory_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK
    } state_t;

    state_t      state_reg, state_next;
    logic        byte_valid_reg, byte_valid_next;
    logic [15:0] len_reg, len_next;
    logic [7:0]  checksum_reg, checksum_next;
    logic [1:0]  lane_reg, lane_next;
    logic [31:0] word_reg, word_next;
    logic [31:0] address_reg, address_next;
    logic [31:0] write_data_reg, write_data_next;
    logic [15:0] word_count_reg, word_count_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        error_reg, error_next;
    logic [15:0] new_len;
    logic [7:0]  final_sum;

    // Only one pop may be in flight; the popped byte is consumed the cycle
    // byte_valid_reg is high, so the next pop can go out the cycle after.
    assign uart_read    = !reset && (state_reg != S_WRITE) && !rx_fifo_empty && !byte_valid_reg;
    assign memory_write = (state_reg == S_WRITE);
    assign address      = address_reg;
    assign write_data   = write_data_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign word_count   = word_count_reg;

    always_comb begin
        state_next      = state_reg;
        byte_valid_next = uart_read;
        len_next        = len_reg;
        checksum_next   = checksum_reg;
        lane_next       = lane_reg;
        word_next       = word_reg;
        address_next    = address_reg;
        write_data_next = write_data_reg;
        word_count_next = word_count_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        error_next      = error_reg;
        new_len         = {uart_read_data, len_reg[7:0]};
        final_sum       = checksum_reg + uart_read_data;

        case (state_reg)
            S_IDLE: begin
                if (byte_valid_reg && uart_read_data == SYNC_BYTE) begin
                    done_next       = 1'b0;
                    error_next      = 1'b0;
                    word_count_next = 16'd0;
                    checksum_next   = 8'd0;
                    lane_next       = 2'd0;
                    busy_next       = 1'b1;
                    state_next      = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (byte_valid_reg) begin
                    len_next[7:0] = uart_read_data;
                    state_next    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (byte_valid_reg) begin
                    len_next = new_len;
                    if (32'(new_len) > MAX_WORDS) begin
                        error_next = 1'b1;
                        busy_next  = 1'b0;
                        state_next = S_IDLE;
                    end else if (new_len == 16'd0) begin
                        state_next = S_CHECK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_valid_reg) begin
                    word_next[{lane_reg, 3'b000} +: 8] = uart_read_data;
                    checksum_next = checksum_reg + uart_read_data;
                    lane_next     = lane_reg + 2'd1;
                    if (lane_reg == 2'd3) begin
                        // Latch the outgoing word so write_data only moves on a write.
                        write_data_next = word_next;
                        address_next    = BASE_ADDRESS + 32'({word_count_reg, 2'b00});
                        state_next      = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_count_next = word_count_reg + 16'd1;
                if (word_count_reg + 16'd1 == len_reg) begin
                    state_next = S_CHECK;
                end else begin
                    state_next = S_DATA;
                end
            end
            S_CHECK: begin
                if (byte_valid_reg) begin
                    if (final_sum == 8'h00) begin
                        done_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                    end
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            byte_valid_reg <= 1'b0;
            len_reg        <= 16'd0;
            checksum_reg   <= 8'd0;
            lane_reg       <= 2'd0;
            word_reg       <= 32'd0;
            address_reg    <= 32'd0;
            write_data_reg <= 32'd0;
            word_count_reg <= 16'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_valid_reg <= byte_valid_next;
            len_reg        <= len_next;
            checksum_reg   <= checksum_next;
            lane_reg       <= lane_next;
            word_reg       <= word_next;
            address_reg    <= address_next;
            write_data_reg <= write_data_next;
            word_count_reg <= word_count_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
        end
    end

endmodule
